// File: rtl/led_stream_monitor_if.sv
// LED stream bus: the 8-bit LED value from the streamer plus the monitor's classification results.
// The master drives led_in and observes the results; the slave is the monitor itself.
interface led_stream_monitor_if;
    logic [7:0] led_in;
    logic       mode_det;
    logic       locked;
    logic       step_pulse;
    logic       err_pulse;
    logic [7:0] err_cnt;

    modport master (
        output led_in,
        input  mode_det,
        input  locked,
        input  step_pulse,
        input  err_pulse,
        input  err_cnt
    );

    modport slave (
        input  led_in,
        output mode_det,
        output locked,
        output step_pulse,
        output err_pulse,
        output err_cnt
    );
endinterface

// File: rtl/led_stream_monitor.sv
// Classifies a running-light LED stream as rotate-left or rotate-right and locks after LOCK_STEPS steps.
// Optional macro LED_MON_STALL_EN adds a stall timer that treats a missing step as a fault.
module led_stream_monitor #(
    parameter int unsigned STEP_CYCLES = 1000000,
    parameter int unsigned LOCK_STEPS  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    led_stream_monitor_if.slave   bus,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int unsigned    RUN_W    = $clog2(LOCK_STEPS + 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_STEPS);

    state_t             state;
    logic [7:0]         led_q;
    logic               cand_dir;
    logic [RUN_W-1:0]   run;
    logic               mode_det_r;
    logic               locked_r;
    logic               step_pulse_r;
    logic               err_pulse_r;
    logic [7:0]         err_cnt_r;

    logic               change;
    logic               one_hot;
    logic               step_l;
    logic               step_r;
    logic               valid;
    logic               dir;
    logic               stall;
    logic               fault;
    logic [RUN_W-1:0]   run_inc;

    // A step is only meaningful from a one-hot previous value; its single-bit rotation is the next frame.
    assign change  = (bus.led_in != led_q);
    assign one_hot = (led_q != 8'h00) && ((led_q & (led_q - 8'd1)) == 8'h00);
    assign step_l  = one_hot && (bus.led_in == {led_q[6:0], led_q[7]});
    assign step_r  = one_hot && (bus.led_in == {led_q[0], led_q[7:1]});
    assign valid   = step_l || step_r;
    assign dir     = step_r;
    assign fault   = (change && !valid) || stall;
    assign run_inc = run + RUN_ONE;

`ifdef LED_MON_STALL_EN
    localparam int unsigned TIMER_TC = 2 * STEP_CYCLES - 1;
    localparam int unsigned TIMER_W  = $clog2(TIMER_TC + 1);

    logic [TIMER_W-1:0] timer;

    // A change in the terminal cycle restarts the count instead of flagging a stall.
    assign stall = !change && (timer == TIMER_W'(TIMER_TC));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer <= '0;
        end else if (change || stall) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end
`else
    // No timer in this build; STEP_CYCLES is referenced so both builds share one parameter list.
    assign stall = (STEP_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            led_q        <= 8'h00;
            cand_dir     <= 1'b0;
            run          <= '0;
            mode_det_r   <= 1'b0;
            locked_r     <= 1'b0;
            step_pulse_r <= 1'b0;
            err_pulse_r  <= 1'b0;
            err_cnt_r    <= 8'h00;
        end else begin
            led_q        <= bus.led_in;
            step_pulse_r <= valid;
            err_pulse_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        cand_dir <= dir;
                        run      <= RUN_ONE;
                        if (LOCK_STEPS == 1) begin
                            state      <= LOCKED;
                            locked_r   <= 1'b1;
                            mode_det_r <= dir;
                        end else begin
                            state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (valid) begin
                        if (dir == cand_dir) begin
                            run <= run_inc;
                            if (run_inc == RUN_LOCK) begin
                                state      <= LOCKED;
                                locked_r   <= 1'b1;
                                mode_det_r <= cand_dir;
                            end
                        end else begin
                            cand_dir <= dir;
                            run      <= RUN_ONE;
                        end
                    end else if (fault) begin
                        state <= IDLE;
                        run   <= '0;
                    end
                end
                LOCKED: begin
                    if (valid) begin
                        if (dir != cand_dir) begin
                            cand_dir <= dir;
                            run      <= RUN_ONE;
                            // With a single-step lock a reversal relocks at once in the new direction.
                            if (LOCK_STEPS == 1) begin
                                mode_det_r <= dir;
                            end else begin
                                state    <= TRACK;
                                locked_r <= 1'b0;
                            end
                        end
                    end else if (fault) begin
                        state       <= IDLE;
                        run         <= '0;
                        locked_r    <= 1'b0;
                        err_pulse_r <= 1'b1;
                        if (err_cnt_r != 8'hFF) begin
                            err_cnt_r <= err_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mode_det   = mode_det_r;
    assign bus.locked     = locked_r;
    assign bus.step_pulse = step_pulse_r;
    assign bus.err_pulse  = err_pulse_r;
    assign bus.err_cnt    = err_cnt_r;
    assign state_dbg      = state;

endmodule
